// File: rtl/mux_scan_ctrl_if.sv
// Scan controller <-> MUX_4to1 / requester bundle.
// slave: the scan controller. master: whoever drives start and the mux output.
interface mux_scan_ctrl_if;
   logic       start;
   logic       mux_out;
   logic [1:0] sel;
   logic       busy;
   logic       done;
   logic [3:0] data;

   modport master (
      output start,
      output mux_out,
      input  sel,
      input  busy,
      input  done,
      input  data
   );

   modport slave (
      input  start,
      input  mux_out,
      output sel,
      output busy,
      output done,
      output data
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 bit mux: walks sel 0..3, holds each select for
// DWELL cycles, samples mux_out on the last dwell cycle and publishes the
// assembled 4-bit word with a one-cycle done pulse.
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 2,
   parameter int unsigned CNT_W = 4
) (
   input logic            clk,
   input logic            rst_n,
   mux_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   state_t           state_q;
   logic [1:0]       sel_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [3:0]       data_q;
   logic [2:0]       shadow_q;   // samples for sel 0..2; sel 3 goes straight to data

   logic             last_dwell_d;
   logic [CNT_W-1:0] cnt_inc_d;

   // Sample-cycle decode and dwell counter increment.
   always_comb begin
      last_dwell_d = (cnt_q == CNT_LAST);
      cnt_inc_d    = cnt_q + CNT_W'(1);
   end

   // Scan FSM; every output is driven straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sel_q    <= 2'd0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         data_q   <= 4'b0000;
         shadow_q <= 3'b000;
      end else begin
         case (state_q)
            S_IDLE: begin
               sel_q  <= 2'd0;
               cnt_q  <= '0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q <= S_SCAN;
                  busy_q  <= 1'b1;
               end
            end

            S_SCAN: begin
               if (last_dwell_d) begin
                  cnt_q <= '0;
                  case (sel_q)
                     2'd0: begin
                        shadow_q[0] <= bus.mux_out;
                        sel_q       <= 2'd1;
                     end
                     2'd1: begin
                        shadow_q[1] <= bus.mux_out;
                        sel_q       <= 2'd2;
                     end
                     2'd2: begin
                        shadow_q[2] <= bus.mux_out;
                        sel_q       <= 2'd3;
                     end
                     default: begin
                        // Final select: publish the word in the same edge that raises done.
                        state_q <= S_DONE;
                        data_q  <= {bus.mux_out, shadow_q};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        sel_q   <= 2'd0;
                     end
                  endcase
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            S_DONE: begin
               // One-cycle pulse; start is deliberately not looked at here.
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               sel_q   <= 2'd0;
               cnt_q   <= '0;
            end

            default: begin
               state_q <= S_IDLE;
               sel_q   <= 2'd0;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Registered outputs onto the bundle.
   always_comb begin
      bus.sel  = sel_q;
      bus.busy = busy_q;
      bus.done = done_q;
      bus.data = data_q;
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: three instances (DWELL 2, 1, 3), each
// with a behavioural 4:1 mux model feeding mux_out from its own In vector.
module tb_mux_scan_ctrl;

   logic clk;
   logic rst_n;
   logic [3:0] in2, in1, in3;
   int n_chk, n_fail;

   mux_scan_ctrl_if if2 ();
   mux_scan_ctrl_if if1 ();
   mux_scan_ctrl_if if3 ();

   mux_scan_ctrl #(.DWELL(2), .CNT_W(4)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2));
   mux_scan_ctrl #(.DWELL(1), .CNT_W(4)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   mux_scan_ctrl #(.DWELL(3), .CNT_W(4)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   // MUX_4to1 models
   assign if2.mux_out = in2[if2.sel];
   assign if1.mux_out = in1[if1.sel];
   assign if3.mux_out = in3[if3.sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0;
      in2 = 4'b0; in1 = 4'b0; in3 = 4'b0;
      if2.start = 1'b0; if1.start = 1'b0; if3.start = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_sel",  32'(if2.sel),  0);
      chk("rst_busy", 32'(if2.busy), 0);
      chk("rst_done", 32'(if2.done), 0);
      chk("rst_data", 32'(if2.data), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: DWELL=2, In=1010, single start pulse
      in2 = 4'b1010; if2.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if2.start = 1'b0;
         chk("t1_sel",  32'(if2.sel),  (c <= 8) ? (c - 1) / 2 : 0);
         chk("t1_busy", 32'(if2.busy), 32'(c <= 8));
         chk("t1_done", 32'(if2.done), 32'(c == 9));
         chk("t1_data", 32'(if2.data), (c >= 9) ? 32'b1010 : 32'b0000);
      end

      // T2: DWELL=1, In=0110
      in1 = 4'b0110; if1.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if1.start = 1'b0;
         chk("t2_sel",  32'(if1.sel),  (c <= 4) ? c - 1 : 0);
         chk("t2_done", 32'(if1.done), 32'(c == 5));
         if (c >= 5) chk("t2_data", 32'(if1.data), 32'b0110);
      end

      // T3: DWELL=2, start held high, In=1111; period 10
      in2 = 4'b1111; if2.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 29) if2.start = 1'b0;
         chk("t3_done", 32'(if2.done), 32'(c % 10 == 9));
         chk("t3_busy", 32'(if2.busy), 32'((c % 10 >= 1) && (c % 10 <= 8)));
      end
      chk("t3_data", 32'(if2.data), 32'b1111);

      // T4: DWELL=2, In=0101, extra starts in cycles 3 and 9 ignored
      in2 = 4'b0101; if2.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if2.start = (c == 3) || (c == 9);
         chk("t4_done", 32'(if2.done), 32'(c == 9));
         chk("t4_busy", 32'(if2.busy), 32'(c <= 8));
      end
      if2.start = 1'b0;
      chk("t4_data", 32'(if2.data), 32'b0101);

      // T5: scan to 0011, then abort a 1100 scan with async reset in cycle 5
      in2 = 4'b0011; if2.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if2.start = 1'b0;
      end
      chk("t5_data1", 32'(if2.data), 32'b0011);
      in2 = 4'b1100; if2.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if2.start = 1'b0;
      end
      chk("t5_presel", 32'(if2.sel), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_sel",  32'(if2.sel),  0);
      chk("t5_rst_busy", 32'(if2.busy), 0);
      chk("t5_rst_done", 32'(if2.done), 0);
      chk("t5_rst_data", 32'(if2.data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk("t5_nodone", 32'(if2.done), 0);
         chk("t5_nobusy", 32'(if2.busy), 0);
      end
      if2.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if2.start = 1'b0;
      end
      chk("t5_done2", 32'(if2.done), 1);
      chk("t5_data2", 32'(if2.data), 32'b1100);

      // T6: DWELL=3, glitch on In[0] outside the sample cycle is not captured
      in3 = 4'b0000; if3.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if3.start = 1'b0;
         if (c == 1) in3[0] = 1'b1;
         if (c == 3) in3[0] = 1'b0;
         if (c <= 12) chk("t6_sel", 32'(if3.sel), (c - 1) / 3);
         chk("t6_done", 32'(if3.done), 32'(c == 13));
         if (c == 13) chk("t6_data", 32'(if3.data), 32'b0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
